// File: rtl/lsu_pkg.sv
// Shared types and constants for the word load/store unit that drives a byte-wide data memory.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DRAIN,
        ST_RESP
    } lsu_state_t;

    localparam int LSU_BEATS = 4;
    localparam int LANE_W    = 8;
    localparam int BEAT_W    = $clog2(LSU_BEATS);

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte lane steering: picks the store byte for a beat and merges a returned load byte into the word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0]       word,
    input  logic [BEAT_W-1:0] wsel,
    output logic [LANE_W-1:0] wbyte,
    input  logic [31:0]       asm_word,
    input  logic [BEAT_W-1:0] rsel,
    input  logic              rd_en,
    input  logic [LANE_W-1:0] rd_byte,
    output logic [31:0]       asm_next
);

    always_comb begin
        wbyte    = word[wsel*LANE_W +: LANE_W];
        asm_next = asm_word;
        if (rd_en) begin
            asm_next[rsel*LANE_W +: LANE_W] = rd_byte;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Word lw/sw engine over an 8-bit memory: four little-endian byte beats per access.
// Optional alignment rejection is enabled by defining LSU_ALIGN_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LSU_BEATS - 1);

    lsu_state_t        state;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] next_beat;
    logic              cap_write;
    logic [31:0]       cap_word;
    logic [31:0]       asm_word;
    logic [31:0]       asm_next;
    logic              rd_en_q;
    logic [BEAT_W-1:0] rd_sel_q;
    logic [LANE_W-1:0] wbyte_next;
    logic              misaligned;

    assign next_beat = beat + BEAT_W'(1);

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = (req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    lsu_byte_lane u_lane (
        .word     (cap_word),
        .wsel     (next_beat),
        .wbyte    (wbyte_next),
        .asm_word (asm_word),
        .rsel     (rd_sel_q),
        .rd_en    (rd_en_q),
        .rd_byte  (mem_rdata),
        .asm_next (asm_next)
    );

    // Memory read data lags the strobe by one cycle, so the lane index and
    // enable are delayed copies of the beat counter and read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            beat      <= '0;
            cap_write <= 1'b0;
            cap_word  <= '0;
            asm_word  <= '0;
            rd_en_q   <= 1'b0;
            rd_sel_q  <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            rd_en_q  <= mem_re;
            rd_sel_q <= beat;
            asm_word <= asm_next;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_write <= req_write;
                        cap_word  <= req_wdata;
                        beat      <= '0;
                        asm_word  <= '0;
                        req_ready <= 1'b0;
                        if (misaligned) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= ST_ACCESS;
                            mem_addr  <= req_addr;
                            mem_we    <= req_write;
                            mem_re    <= ~req_write;
                            mem_wdata <= req_write ? req_wdata[LANE_W-1:0] : '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (beat == LAST_BEAT) begin
                        state     <= ST_DRAIN;
                        mem_addr  <= '0;
                        mem_re    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                    end else begin
                        beat      <= next_beat;
                        mem_addr  <= mem_addr + 32'd1;
                        mem_wdata <= cap_write ? wbyte_next : '0;
                    end
                end
                ST_DRAIN: begin
                    state     <= ST_RESP;
                    beat      <= '0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= cap_write ? 32'd0 : asm_next;
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-wide memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [logic [31:0]];

    int          nbeats;
    logic [31:0] b_addr [8];
    logic [7:0]  b_data [8];
    logic        b_we   [8];
    int          b_cyc  [8];
    int          rsp_cnt;
    int          rsp_cyc;
    logic [31:0] rsp_d;
    logic        rsp_e;
    logic        both;
    logic        rdy_seen;

    load_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (mem_re) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
    end

    // Issue one request at a falling edge and log strobes/responses for ncyc cycles.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input int ncyc);
        nbeats = 0; rsp_cnt = 0; rsp_cyc = -1; rsp_d = '0; rsp_e = 1'b0; both = 1'b0;
        rdy_seen = req_ready;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (mem_we && mem_re) both = 1'b1;
            if (mem_we || mem_re) begin
                if (nbeats < 8) begin
                    b_addr[nbeats] = mem_addr;
                    b_data[nbeats] = mem_wdata;
                    b_we[nbeats]   = mem_we;
                    b_cyc[nbeats]  = c;
                end
                nbeats++;
            end
            if (rsp_valid) begin
                rsp_cnt++; rsp_cyc = c; rsp_d = rsp_rdata; rsp_e = rsp_err;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        n_cmp++; if ({mem_re, mem_we} !== 2'b00) begin n_err++; $display("FAIL reset_strobes got %b want 00", {mem_re, mem_we}); end
        n_cmp++; if (mem_addr !== 32'd0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 8'd0) begin n_err++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_store();
        logic [7:0] eb [4];
        eb[0] = 8'hD4; eb[1] = 8'hC3; eb[2] = 8'hB2; eb[3] = 8'hA1;
        issue(1'b1, 32'h10, 32'hA1B2C3D4, 8);
        n_cmp++; if (rdy_seen !== 1'b1) begin n_err++; $display("FAIL store_ready got %b want 1", rdy_seen); end
        n_cmp++; if (nbeats !== 4) begin n_err++; $display("FAIL store_nbeats got %0d want 4", nbeats); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (b_addr[k] !== 32'h10 + k || b_data[k] !== eb[k] || b_we[k] !== 1'b1 || b_cyc[k] !== k + 1) begin
                n_err++;
                $display("FAIL store_beat%0d got addr %h data %h we %b cyc %0d want addr %h data %h we 1 cyc %0d",
                         k, b_addr[k], b_data[k], b_we[k], b_cyc[k], 32'h10 + k, eb[k], k + 1);
            end
        end
        n_cmp++; if (rsp_cnt !== 1 || rsp_cyc !== 6) begin n_err++; $display("FAIL store_rsp_timing got cnt %0d cyc %0d want 1 at 6", rsp_cnt, rsp_cyc); end
        n_cmp++; if (rsp_d !== 32'd0 || rsp_e !== 1'b0) begin n_err++; $display("FAIL store_rsp got rdata %h err %b want 0/0", rsp_d, rsp_e); end
        n_cmp++; if (both !== 1'b0) begin n_err++; $display("FAIL store_strobe_overlap got 1 want 0"); end
    endtask

    task automatic test_load();
        issue(1'b0, 32'h10, 32'h0, 8);
        n_cmp++; if (nbeats !== 4) begin n_err++; $display("FAIL load_nbeats got %0d want 4", nbeats); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (b_addr[k] !== 32'h10 + k || b_we[k] !== 1'b0 || b_cyc[k] !== k + 1) begin
                n_err++;
                $display("FAIL load_beat%0d got addr %h we %b cyc %0d want addr %h we 0 cyc %0d",
                         k, b_addr[k], b_we[k], b_cyc[k], 32'h10 + k, k + 1);
            end
        end
        n_cmp++; if (rsp_cyc !== 6) begin n_err++; $display("FAIL load_rsp_cyc got %0d want 6", rsp_cyc); end
        n_cmp++; if (rsp_d !== 32'hA1B2C3D4 || rsp_e !== 1'b0) begin n_err++; $display("FAIL load_rsp got rdata %h err %b want a1b2c3d4/0", rsp_d, rsp_e); end
    endtask

    task automatic test_back_to_back();
        int acc2;
        int early_ready;
        int rc;
        int r_cyc [2];
        logic [31:0] r_dat [2];
        acc2 = -1; early_ready = 0; rc = 0;
        r_cyc[0] = -1; r_cyc[1] = -1; r_dat[0] = 'x; r_dat[1] = 'x;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h11223344;
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) begin req_write = 1'b0; req_wdata = 32'hFFFFFFFF; end
            if (acc2 >= 0 && c == acc2 + 1) req_valid = 1'b0;
            if (req_ready === 1'b1 && acc2 < 0) acc2 = c;
            if (req_ready === 1'b1 && c < 7) early_ready++;
            if (rsp_valid) begin
                if (rc < 2) begin r_cyc[rc] = c; r_dat[rc] = rsp_rdata; end
                rc++;
            end
        end
        req_valid = 1'b0;
        n_cmp++; if (acc2 !== 7) begin n_err++; $display("FAIL b2b_second_accept got cyc %0d want 7", acc2); end
        n_cmp++; if (early_ready !== 0) begin n_err++; $display("FAIL b2b_ready_busy got %0d high cycles want 0", early_ready); end
        n_cmp++; if (rc !== 2) begin n_err++; $display("FAIL b2b_rsp_count got %0d want 2", rc); end
        n_cmp++; if (r_cyc[0] !== 6 || r_dat[0] !== 32'd0) begin n_err++; $display("FAIL b2b_rsp0 got cyc %0d data %h want 6/0", r_cyc[0], r_dat[0]); end
        n_cmp++; if (r_cyc[1] !== 13 || r_dat[1] !== 32'h11223344) begin n_err++; $display("FAIL b2b_rsp1 got cyc %0d data %h want 13/11223344", r_cyc[1], r_dat[1]); end
    endtask

`ifdef LSU_ALIGN_CHECK_EN
    task automatic test_align_err();
        issue(1'b0, 32'h13, 32'h0, 8);
        n_cmp++; if (nbeats !== 0) begin n_err++; $display("FAIL align_nbeats got %0d want 0", nbeats); end
        n_cmp++; if (rsp_cnt !== 1 || rsp_cyc !== 1) begin n_err++; $display("FAIL align_rsp_timing got cnt %0d cyc %0d want 1 at 1", rsp_cnt, rsp_cyc); end
        n_cmp++; if (rsp_e !== 1'b1 || rsp_d !== 32'd0) begin n_err++; $display("FAIL align_rsp got err %b rdata %h want 1/0", rsp_e, rsp_d); end
    endtask
`else
    task automatic test_wrap();
        logic [31:0] ea [4];
        logic [7:0]  eb [4];
        ea[0] = 32'hFFFFFFFE; ea[1] = 32'hFFFFFFFF; ea[2] = 32'h0; ea[3] = 32'h1;
        eb[0] = 8'h88; eb[1] = 8'h77; eb[2] = 8'h66; eb[3] = 8'h55;
        issue(1'b1, 32'hFFFFFFFE, 32'h55667788, 8);
        n_cmp++; if (nbeats !== 4) begin n_err++; $display("FAIL wrap_nbeats got %0d want 4", nbeats); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (b_addr[k] !== ea[k] || b_data[k] !== eb[k]) begin
                n_err++;
                $display("FAIL wrap_beat%0d got addr %h data %h want addr %h data %h", k, b_addr[k], b_data[k], ea[k], eb[k]);
            end
        end
        n_cmp++; if (rsp_e !== 1'b0) begin n_err++; $display("FAIL wrap_err got %b want 0", rsp_e); end
        issue(1'b0, 32'hFFFFFFFE, 32'h0, 8);
        n_cmp++; if (rsp_d !== 32'h55667788) begin n_err++; $display("FAIL wrap_load got %h want 55667788", rsp_d); end
    endtask
`endif

    task automatic test_reset_mid();
        int bad;
        issue(1'b1, 32'h40, 32'h01020304, 8);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'h42) begin n_err++; $display("FAIL rstmid_beat2 got we %b addr %h want 1/00000042", mem_we, mem_addr); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 32'd0) begin n_err++; $display("FAIL rstmid_drop got we %b addr %h want 0/0", mem_we, mem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mem_we !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rstmid_quiet got %0d active cycles want 0", bad); end
        issue(1'b0, 32'h40, 32'h0, 8);
        n_cmp++; if (rsp_d !== 32'h0102CCDD) begin n_err++; $display("FAIL rstmid_load got %h want 0102ccdd", rsp_d); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_back_to_back();
`ifdef LSU_ALIGN_CHECK_EN
        test_align_err();
`else
        test_wrap();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 CLK  input  1  single clock; all state changes on rising edge.
REQ-002 RESET  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, released synchronously to CLK.
REQ-003 REQ_VALID  input  1  ALU stage presents a lw/sw request.
REQ-004 REQ_READY  output  1  unit can accept a request this cycle.
REQ-005 REQ_WRITE  input  1  1 = store word, 0 = load word.
REQ-006 REQ_ADDR  input  32  byte address (ALU result).
REQ-007 REQ_WDATA  input  32  store data (register file second read port).
REQ-008 RSP_VALID  output  1  one-cycle pulse; access complete.
REQ-009 RSP_RDATA  output  32  load result, valid while RSP_VALID=1; 0 for stores.
REQ-010 RSP_ERR  output  1  access rejected, valid while RSP_VALID=1.
REQ-011 MEM_ADDR  output  32  byte address to 8-bit data memory.
REQ-012 MEM_RE / MEM_WE  output  1 each  byte read / byte write strobes, never both high.
REQ-013 MEM_WDATA  output  8  byte write data.
REQ-014 MEM_RDATA  input  8  byte read data, valid the cycle after MEM_RE.

Function
REQ-015 States: IDLE, ACCESS, DRAIN, RESP; REQ_READY=1 only in IDLE.
REQ-016 Handshake: request accepted on a rising edge with REQ_VALID=1 and REQ_READY=1; REQ_WRITE/ADDR/WDATA captured then; inputs ignored at all other times.
REQ-017 Accept: IDLE -> ACCESS, beat counter = 0.
REQ-018 ACCESS: 4 beats k=0..3, one per cycle; MEM_ADDR = captured addr + k (mod 2^32, wraps past 32'hFFFFFFFF); MEM_RE=~write, MEM_WE=write.
REQ-019 Byte order little-endian: beat k carries/returns bits [8k+7:8k].
REQ-020 Load byte k captured from MEM_RDATA in the cycle after beat k; last byte captured in DRAIN.
REQ-021 ACCESS beat 3 -> DRAIN -> RESP -> IDLE; MEM strobes 0 in DRAIN, RESP, IDLE.
REQ-022 RSP_VALID=1 for exactly the RESP cycle, the 6th cycle after acceptance; no response backpressure.
REQ-023 Minimum spacing between accepted requests: 7 cycles.
REQ-024 RSP_RDATA holds the assembled word during RESP and 0 otherwise; RSP_ERR 0 unless REQ-029 applies.

Reset
REQ-025 RESET=0: state IDLE, beat counter 0, captured registers 0, REQ_READY=1 after release, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, MEM_ADDR=0, MEM_RE=0, MEM_WE=0, MEM_WDATA=0.
REQ-026 Reset mid-access aborts the transaction with no response; strobes drop immediately; bytes already written stay written.
REQ-027 First acceptance possible on the first rising edge after RESET returns to 1.

Configuration
REQ-028 Macro LSU_ALIGN_CHECK_EN selects alignment checking.
REQ-029 Defined: accepted request with REQ_ADDR[1:0]!=0 issues no memory beats; IDLE -> RESP directly; RSP_VALID the cycle after acceptance with RSP_ERR=1, RSP_RDATA=0.
REQ-030 Not defined: RSP_ERR tied 0; any address handled per REQ-018 (unaligned words span addr..addr+3).

Structure
REQ-031 Shared package lsu_pkg holds the state enumeration, LSU_BEATS=4 constant and byte-lane width 8.
REQ-032 One sub-module, lsu_byte_lane, selects write byte k from the captured word and inserts read byte k into the assembly register; FSM and counter stay in load_store_unit.

Verification
REQ-033 Store addr 32'h10, data 32'hA1B2C3D4 -> write beats 0x10..0x13 with bytes D4,C3,B2,A1; RSP_VALID 6 cycles after accept, RSP_RDATA=0.
REQ-034 Load addr 32'h10 after REQ-033 -> MEM_RE beats 0x10..0x13; RSP_RDATA=32'hA1B2C3D4 with RSP_ERR=0.
REQ-035 REQ_VALID held high across two requests -> second accepted exactly 7 cycles after first; REQ_READY=0 throughout.
REQ-036 Store addr 32'hFFFFFFFE without the macro -> MEM_ADDR sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-037 With LSU_ALIGN_CHECK_EN, load addr 32'h13 -> no MEM_RE pulses; RSP_VALID one cycle after accept, RSP_ERR=1, RSP_RDATA=0.
REQ-038 RESET=0 during beat 2 of a store -> MEM_WE drops immediately, no RSP_VALID; next load of that word returns only beats 0-1 updated.
